// File: rtl/method_funnel_serializer.sv
// method_funnel_serializer
// Round-robin funnel from NUM_METHODS request methods onto a narrow pipe.
// Each accepted call becomes the message {payload, tag}, with tag = method + 1
// in the LSBs. The message is zero-padded to a whole number of beats and sent
// little-endian, one beat per transfer, with last on the final beat.
// Optional build macro METHOD_FUNNEL_HDR_EN: each message is preceded by one
// header beat whose bits [15:0] hold BEATS. The header beat never carries last.
module method_funnel_serializer #(
    parameter int NUM_METHODS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 32,
    parameter int BEAT_WIDTH  = 32
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [NUM_METHODS-1:0]            say__ENA,
    input  logic [NUM_METHODS*DATA_WIDTH-1:0] say_v,
    output logic [NUM_METHODS-1:0]            say__RDY,
    output logic                              pipe_enq__ENA,
    output logic [BEAT_WIDTH-1:0]             pipe_enq_v,
    output logic                              pipe_enq_last,
    input  logic                              pipe_enq__RDY
);

    localparam int MSG_WIDTH = TAG_WIDTH + DATA_WIDTH;
    localparam int BEATS     = (MSG_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
    localparam int PAD_WIDTH = BEATS * BEAT_WIDTH;
    localparam int RR_W      = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
    localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    // The counter has room for 0..BEATS, so the header build fits as well.
    localparam int CNT_W     = $clog2(BEATS + 1);
`ifdef METHOD_FUNNEL_HDR_EN
    localparam int LAST_CNT  = BEATS;
`else
    localparam int LAST_CNT  = BEATS - 1;
`endif

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LAST_CNT);
    localparam logic [RR_W:0]    NUM_M     = (RR_W + 1)'(NUM_METHODS);
    localparam logic [RR_W-1:0]  TOP_IDX   = RR_W'(NUM_METHODS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 state_q;
    logic [RR_W-1:0]        rr_q;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [PAD_WIDTH-1:0]   msg_q;

    logic [RR_W-1:0]        rr_d;
    logic [PAD_WIDTH-1:0]   msg_d;
    logic [TAG_WIDTH-1:0]   tag_d;

    logic [DATA_WIDTH-1:0]  payload   [NUM_METHODS];
    logic [BEAT_WIDTH-1:0]  msg_beats [BEATS];

    logic                   grant_valid;
    logic [RR_W-1:0]        grant_idx;
    logic [RR_W:0]          cand_w;
    logic                   last_xfer;
    logic                   accept_window;
    logic                   accept;
    logic [IDX_W-1:0]       pay_idx;
    logic [BEAT_WIDTH-1:0]  beat_v;

    // Slice the flat payload bus and the held message into addressable pieces.
    generate
        for (genvar gi = 0; gi < NUM_METHODS; gi++) begin : g_payload
            assign payload[gi] = say_v[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beats
            assign msg_beats[gi] = msg_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end
    endgenerate

    // Round-robin search: first requester at or after rr_q, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_w      = '0;
        for (int off = 0; off < NUM_METHODS; off++) begin
            cand_w = {1'b0, rr_q} + (RR_W + 1)'(off);
            if (cand_w >= NUM_M) begin
                cand_w = cand_w - NUM_M;
            end
            if (!grant_valid && say__ENA[cand_w[RR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_w[RR_W-1:0];
            end
        end
    end

    // A new call may enter when idle or while the final beat is leaving.
    assign last_xfer     = (state_q == S_SEND) && pipe_enq__RDY && (beat_cnt_q == LAST_BEAT);
    assign accept_window = (state_q == S_IDLE) || last_xfer;

    // Ready is one-hot on the granted method; held low while reset is asserted.
    always_comb begin
        say__RDY = '0;
        if (nRST && accept_window && grant_valid) begin
            say__RDY[grant_idx] = 1'b1;
        end
    end

    assign accept = |say__RDY;

    // Next message image and next pointer for the granted method.
    always_comb begin
        tag_d                  = TAG_WIDTH'(grant_idx) + TAG_WIDTH'(1);
        msg_d                  = '0;
        msg_d[MSG_WIDTH-1:0]   = {payload[grant_idx], tag_d};
        rr_d                   = (grant_idx == TOP_IDX) ? '0 : grant_idx + RR_W'(1);
    end

    // Beat selection from the held message (header first when enabled).
    always_comb begin
        beat_v  = '0;
`ifdef METHOD_FUNNEL_HDR_EN
        pay_idx = IDX_W'(beat_cnt_q - CNT_W'(1));
        if (beat_cnt_q == '0) begin
            beat_v[15:0] = 16'(BEATS);
        end else begin
            beat_v = msg_beats[pay_idx];
        end
`else
        pay_idx = IDX_W'(beat_cnt_q);
        beat_v  = msg_beats[pay_idx];
`endif
    end

    assign pipe_enq__ENA  = (state_q == S_SEND) && pipe_enq__RDY;
    assign pipe_enq_v     = (state_q == S_SEND) ? beat_v : '0;
    assign pipe_enq_last  = (state_q == S_SEND) && (beat_cnt_q == LAST_BEAT);

    // Framing FSM: capture on accept, advance on each transfer, hold otherwise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            beat_cnt_q <= '0;
            msg_q      <= '0;
        end else begin
            if (accept) begin
                state_q    <= S_SEND;
                beat_cnt_q <= '0;
                rr_q       <= rr_d;
                msg_q      <= msg_d;
            end else if (pipe_enq__ENA) begin
                if (beat_cnt_q == LAST_BEAT) begin
                    state_q <= S_IDLE;
                end else begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_method_funnel_serializer.sv
// Bench for method_funnel_serializer at N=4, DATA=64, TAG=32, BEAT=32.
// Expected beats are queued when calls are issued and popped as the pipe
// transfers. Honours METHOD_FUNNEL_HDR_EN when built with it.
module tb_method_funnel_serializer;

    localparam int BEATS = 3;
`ifdef METHOD_FUNNEL_HDR_EN
    localparam int NB = BEATS + 1;
`else
    localparam int NB = BEATS;
`endif

    typedef struct packed {
        logic [31:0] v;
        logic        last;
    } beat_t;

    typedef struct {
        int          m;
        logic [63:0] p;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] b2;
    } vec_t;

    logic         clk;
    logic         nrst;
    logic [3:0]   say_ena;
    logic [255:0] say_v;
    logic [3:0]   say_rdy;
    logic         pipe_ena;
    logic [31:0]  pipe_v;
    logic         pipe_last;
    logic         pipe_rdy;

    beat_t        sb[$];
    beat_t        mon_e;
    int           req_cnt[4];
    logic [3:0]   acc;
    int           n_cmp = 0;
    int           n_bad = 0;
    vec_t         vecs[5];

    method_funnel_serializer #(
        .NUM_METHODS(4),
        .DATA_WIDTH (64),
        .TAG_WIDTH  (32),
        .BEAT_WIDTH (32)
    ) dut (
        .CLK          (clk),
        .nRST         (nrst),
        .say__ENA     (say_ena),
        .say_v        (say_v),
        .say__RDY     (say_rdy),
        .pipe_enq__ENA(pipe_ena),
        .pipe_enq_v   (pipe_v),
        .pipe_enq_last(pipe_last),
        .pipe_enq__RDY(pipe_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_of(input int m, input logic [63:0] p, input int k);
        logic [95:0] msg;
        int          kk;
        msg = {p, 32'(m + 1)};
        kk  = k;
`ifdef METHOD_FUNNEL_HDR_EN
        if (k == 0) return 32'(BEATS);
        kk = k - 1;
`endif
        return msg[kk*32 +: 32];
    endfunction

    function automatic void push_msg(input int m, input logic [63:0] p);
        for (int k = 0; k < NB; k++) begin
            sb.push_back('{v: beat_of(m, p, k), last: (k == NB - 1)});
        end
    endfunction

    function automatic void push_vec(input vec_t r);
`ifdef METHOD_FUNNEL_HDR_EN
        sb.push_back('{v: 32'(BEATS), last: 1'b0});
`endif
        sb.push_back('{v: r.b0, last: 1'b0});
        sb.push_back('{v: r.b1, last: 1'b0});
        sb.push_back('{v: r.b2, last: 1'b1});
    endfunction

    function automatic logic pending();
        return (req_cnt[0] + req_cnt[1] + req_cnt[2] + req_cnt[3]) != 0;
    endfunction

    // Call only between posedge+1 and the following negedge.
    task automatic request(input int m, input logic [63:0] p, input int n);
        say_v[m*64 +: 64] = p;
        req_cnt[m] += n;
        say_ena[m] = 1'b1;
    endtask

    // Requester model: hold ENA and payload until each call is accepted.
    initial begin
        forever begin
            @(negedge clk);
            acc = say_ena & say_rdy;
            @(posedge clk);
            #1;
            for (int m = 0; m < 4; m++) begin
                if (acc[m] && req_cnt[m] > 0) req_cnt[m]--;
                say_ena[m] = (req_cnt[m] > 0);
            end
        end
    end

    // Pipe monitor: one line per transfer, compared against the scoreboard.
    always @(negedge clk) begin
        if (pipe_ena) begin
            check("enq_needs_rdy", pipe_rdy, 1);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got %08h want none", pipe_v);
            end else begin
                mon_e = sb.pop_front();
                $display("beat v=%08h last=%0b (want %08h/%0b)", pipe_v, pipe_last, mon_e.v, mon_e.last);
                check("beat_data", pipe_v, mon_e.v);
                check("beat_last", pipe_last, mon_e.last);
            end
        end
        if ($countones(say_ena) > 1) check("rdy_onehot", $countones(say_rdy) <= 1, 1);
        if (say_ena != 0 && pipe_ena && !pipe_last) check("rdy_low_midmsg", say_rdy, 0);
        if (say_rdy != 0) check("rdy_only_enabled", say_rdy & ~say_ena, 0);
    end

    task automatic check_stream(input string name, input int n);
        int w = 0;
        int c = 1;
        @(negedge clk);
        while (!pipe_ena && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({name, "_start"}, pipe_ena, 1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            if (pipe_ena) c++;
        end
        check({name, "_run"}, c, n);
        @(negedge clk);
        check({name, "_end"}, pipe_ena, 0);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while ((sb.size() != 0 || pending()) && c < 60) begin
            @(negedge clk);
            c++;
        end
        check({name, "_drained"}, (sb.size() == 0) && !pending(), 1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_first_xfer(input string name);
        int w = 0;
        @(negedge clk);
        while (!pipe_ena && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({name, "_first_xfer"}, pipe_ena, 1);
    endtask

    initial begin
        vecs[0] = '{m: 1, p: 64'h1111_2222_3333_4444, b0: 32'h0000_0002, b1: 32'h3333_4444, b2: 32'h1111_2222};
        vecs[1] = '{m: 0, p: 64'hDEAD_BEEF_0123_4567, b0: 32'h0000_0001, b1: 32'h0123_4567, b2: 32'hDEAD_BEEF};
        vecs[2] = '{m: 3, p: 64'h0000_0000_0000_0000, b0: 32'h0000_0004, b1: 32'h0000_0000, b2: 32'h0000_0000};
        vecs[3] = '{m: 2, p: 64'hFFFF_FFFF_FFFF_FFFF, b0: 32'h0000_0003, b1: 32'hFFFF_FFFF, b2: 32'hFFFF_FFFF};
        vecs[4] = '{m: 1, p: 64'h8000_0000_0000_0001, b0: 32'h0000_0002, b1: 32'h0000_0001, b2: 32'h8000_0000};

        nrst     = 1'b0;
        pipe_rdy = 1'b1;
        say_v    = '0;
        say_ena  = '0;
        for (int m = 0; m < 4; m++) req_cnt[m] = 0;

        // Reset state with two requesters waiting, then contention on release.
        request(0, 64'hA0A0_A0A0_0000_0000, 1);
        request(2, 64'hC2C2_C2C2_2222_2222, 1);
        #12;
        check("rst_say_rdy", say_rdy, 0);
        check("rst_enq_ena", pipe_ena, 0);
        check("rst_enq_v", pipe_v, 0);
        check("rst_enq_last", pipe_last, 0);
        push_msg(0, 64'hA0A0_A0A0_0000_0000);
        push_msg(2, 64'hC2C2_C2C2_2222_2222);
        @(posedge clk);
        #3;
        nrst = 1'b1;
        check_stream("contention", 2 * NB);
        wait_drain("contention");

        // Single call: ready while idle, beat 0 in the cycle after the accept.
        request(1, 64'h1111_2222_3333_4444, 1);
        push_msg(1, 64'h1111_2222_3333_4444);
        @(negedge clk);
        check("idle_rdy", say_rdy, 4'b0010);
        @(negedge clk);
        check("latency_beat0", pipe_ena, 1);
        wait_drain("single");

        // Table of single calls with hand-written expected beats.
        for (int i = 0; i < 5; i++) begin
            request(vecs[i].m, vecs[i].p, 1);
            push_vec(vecs[i]);
            wait_drain($sformatf("vec%0d", i));
        end

        // Backpressure while beat 1 is pending.
        request(1, 64'h1111_2222_3333_4444, 1);
        push_msg(1, 64'h1111_2222_3333_4444);
        wait_first_xfer("bp");
        @(posedge clk);
        #2;
        pipe_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_no_ena", pipe_ena, 0);
            check("bp_v_stable", pipe_v, beat_of(1, 64'h1111_2222_3333_4444, 1));
            check("bp_no_last", pipe_last, 0);
            @(posedge clk);
            #2;
        end
        pipe_rdy = 1'b1;
        for (int k = 1; k < NB; k++) begin
            @(negedge clk);
            check("bp_resume_ena", pipe_ena, 1);
        end
        check("bp_resume_last", pipe_last, 1);
        @(negedge clk);
        check("bp_done", pipe_ena, 0);
        wait_drain("bp");

        // Streaming and fairness from a fresh pointer: tags 1,4,1,4.
        @(posedge clk);
        #3;
        nrst = 1'b0;
        @(posedge clk);
        #3;
        nrst = 1'b1;
        @(posedge clk);
        #2;
        request(0, 64'h0F0F_0000_0000_F0F0, 2);
        request(3, 64'h3333_CCCC_CCCC_3333, 2);
        push_msg(0, 64'h0F0F_0000_0000_F0F0);
        push_msg(3, 64'h3333_CCCC_CCCC_3333);
        push_msg(0, 64'h0F0F_0000_0000_F0F0);
        push_msg(3, 64'h3333_CCCC_CCCC_3333);
        check_stream("stream", 4 * NB);
        wait_drain("stream");

        // Reset in the middle of a method 2 message.
        request(2, 64'h2222_AAAA_BBBB_CCCC, 1);
        push_msg(2, 64'h2222_AAAA_BBBB_CCCC);
        wait_first_xfer("midrst");
        @(posedge clk);
        #2;
        request(0, 64'h0000_0000_0000_0005, 1);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("midrst_say_rdy", say_rdy, 0);
        check("midrst_enq_ena", pipe_ena, 0);
        check("midrst_enq_v", pipe_v, 0);
        check("midrst_enq_last", pipe_last, 0);
        @(posedge clk);
        #2;
        for (int m = 0; m < 4; m++) req_cnt[m] = 0;
        say_ena = '0;
        sb.delete();
        @(posedge clk);
        #3;
        nrst = 1'b1;
        // With the pointer back at 0, method 1 wins over method 3.
        request(1, 64'h1234_5678_9ABC_DEF0, 1);
        request(3, 64'h0FED_CBA9_8765_4321, 1);
        push_msg(1, 64'h1234_5678_9ABC_DEF0);
        push_msg(3, 64'h0FED_CBA9_8765_4321);
        check_stream("post_rst", 2 * NB);
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
